// File: rtl/vending_pkg.sv
// Shared definitions for the multi-product vending controller.
//   coin_e      : coin codes on the acceptor/hopper buses (none/5/10/20 rs)
//   state_e     : controller state, also exported on c_state
//   coin_value  : coin code -> credit units (1 unit = 5 rs)
//   greedy_coin : largest coin not exceeding the remaining credit
package vending_pkg;

  typedef enum logic [1:0] {
    COIN_NONE = 2'b00,
    COIN_5    = 2'b01,
    COIN_10   = 2'b10,
    COIN_20   = 2'b11
  } coin_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_CREDIT   = 2'b01,
    ST_DISPENSE = 2'b10,
    ST_CHANGE   = 2'b11
  } state_e;

  function automatic logic [2:0] coin_value(input logic [1:0] code);
    case (code)
      COIN_5:  return 3'd1;
      COIN_10: return 3'd2;
      COIN_20: return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic [1:0] greedy_coin(input logic [31:0] credit);
    if (credit >= 32'd4) return COIN_20;
    if (credit >= 32'd2) return COIN_10;
    if (credit != 32'd0) return COIN_5;
    return COIN_NONE;
  endfunction

endpackage

// File: rtl/vending_machine_multi_stock.sv
// Per-item stock counters for the vending controller.
//   clk, rst   : clock, async active-high reset (loads STOCK_INIT everywhere)
//   dec_en     : decrement stock[dec_sel] (saturates at zero)
//   reload_en  : load stock[reload_sel] with STOCK_INIT
//   sold_out   : bit i set while stock[i] == 0 (combinational)
module vend_stock_bank
  import vending_pkg::*;
#(
  parameter int unsigned NUM_ITEMS  = 4,
  parameter int unsigned SEL_W      = 2,
  parameter int unsigned STOCK_W    = 4,
  parameter int unsigned STOCK_INIT = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 dec_en,
  input  logic [SEL_W-1:0]     dec_sel,
  input  logic                 reload_en,
  input  logic [SEL_W-1:0]     reload_sel,
  output logic [NUM_ITEMS-1:0] sold_out
);

  logic [STOCK_W-1:0] stock_q [NUM_ITEMS];
  logic [STOCK_W-1:0] stock_d [NUM_ITEMS];

  always_comb begin
    stock_d = stock_q;
    for (int unsigned i = 0; i < NUM_ITEMS; i++) begin
      if (reload_en && reload_sel == SEL_W'(i)) begin
        stock_d[i] = STOCK_W'(STOCK_INIT);
      end else if (dec_en && dec_sel == SEL_W'(i) && stock_q[i] != '0) begin
        stock_d[i] = stock_q[i] - STOCK_W'(1);
      end
    end
  end

  always_comb begin
    sold_out = '0;
    for (int unsigned i = 0; i < NUM_ITEMS; i++) begin
      sold_out[i] = (stock_q[i] == '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_ITEMS; i++) begin
        stock_q[i] <= STOCK_W'(STOCK_INIT);
      end
    end else begin
      stock_q <= stock_d;
    end
  end

endmodule

// File: rtl/vending_machine_multi.sv
// Multi-product vending controller with 5/10/20 rs coins, cancel/refund and
// one-coin-per-cycle greedy change return.
//   in          : coin code from acceptor (00 none, 01 5rs, 10 10rs, 11 20rs)
//   sel         : item index for vend_req / restock
//   vend_req    : purchase request
//   cancel      : refund all credit
//   restock     : reload stock[sel]
//   out, item   : one-cycle dispense pulse and dispensed item index
//   change      : returned coin code, one per cycle
//   coin_reject : one-cycle pulse, coin returned without credit
//   vend_fail   : one-cycle pulse, purchase refused
//   busy        : high in DISPENSE/CHANGE
//   sold_out    : per-item empty flags (combinational)
//   credit      : current credit in 5 rs units
//   c_state     : 00 IDLE, 01 CREDIT, 10 DISPENSE, 11 CHANGE
module vending_machine_multi
  import vending_pkg::*;
#(
  parameter int unsigned NUM_ITEMS  = 4,
  parameter int unsigned PRICE_W    = 6,
  parameter logic [NUM_ITEMS*PRICE_W-1:0] ITEM_PRICES = {6'd8, 6'd5, 6'd4, 6'd3},
  parameter int unsigned CREDIT_W   = 6,
  parameter int unsigned MAX_CREDIT = 40,
  parameter int unsigned STOCK_W    = 4,
  parameter int unsigned STOCK_INIT = 5,
  localparam int unsigned SEL_W     = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           in,
  input  logic [SEL_W-1:0]     sel,
  input  logic                 vend_req,
  input  logic                 cancel,
  input  logic                 restock,
  output logic                 out,
  output logic [SEL_W-1:0]     item,
  output logic [1:0]           change,
  output logic                 coin_reject,
  output logic                 vend_fail,
  output logic                 busy,
  output logic [NUM_ITEMS-1:0] sold_out,
  output logic [CREDIT_W-1:0]  credit,
  output logic [1:0]           c_state
);

  // One extra bit so credit + coin and price comparisons cannot overflow.
  localparam int unsigned SUM_W = ((CREDIT_W > PRICE_W) ? CREDIT_W : PRICE_W) + 1;

  state_e              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic                out_q, out_d;
  logic [SEL_W-1:0]    item_q, item_d;
  logic [1:0]          change_q, change_d;
  logic                coin_reject_q, coin_reject_d;
  logic                vend_fail_q, vend_fail_d;
  logic                busy_q, busy_d;

  logic                dec_en, reload_en;
  logic                sel_ok, sel_empty;
  logic [PRICE_W-1:0]  sel_price;
  logic [SUM_W-1:0]    credit_ext, price_ext, coin_ext, sum_ext;
  logic                coin_present;
  logic [1:0]          gc;

  vend_stock_bank #(
    .NUM_ITEMS (NUM_ITEMS),
    .SEL_W     (SEL_W),
    .STOCK_W   (STOCK_W),
    .STOCK_INIT(STOCK_INIT)
  ) u_stock (
    .clk       (clk),
    .rst       (rst),
    .dec_en    (dec_en),
    .dec_sel   (sel),
    .reload_en (reload_en),
    .reload_sel(sel),
    .sold_out  (sold_out)
  );

  always_comb begin
    sel_ok    = 1'b0;
    sel_empty = 1'b0;
    sel_price = '0;
    for (int unsigned i = 0; i < NUM_ITEMS; i++) begin
      if (sel == SEL_W'(i)) begin
        sel_ok    = 1'b1;
        sel_empty = sold_out[i];
        sel_price = ITEM_PRICES[i*PRICE_W +: PRICE_W];
      end
    end
  end

  always_comb begin
    credit_ext   = SUM_W'(credit_q);
    price_ext    = SUM_W'(sel_price);
    coin_ext     = SUM_W'(coin_value(in));
    sum_ext      = credit_ext + coin_ext;
    coin_present = (in != COIN_NONE);
    gc           = greedy_coin(32'(credit_q));

    state_d       = state_q;
    credit_d      = credit_q;
    out_d         = 1'b0;
    item_d        = item_q;
    change_d      = COIN_NONE;
    coin_reject_d = 1'b0;
    vend_fail_d   = 1'b0;
    dec_en        = 1'b0;
    reload_en     = 1'b0;

    case (state_q)
      ST_IDLE, ST_CREDIT: begin
        // Cancel with no credit is a no-op and lets lower-priority events through.
        if (cancel && credit_q != '0) begin
          state_d       = ST_CHANGE;
          coin_reject_d = coin_present;
        end else if (vend_req) begin
          coin_reject_d = coin_present;
          if (!sel_ok || sel_empty || credit_ext < price_ext) begin
            vend_fail_d = 1'b1;
            state_d     = (credit_q != '0) ? ST_CREDIT : ST_IDLE;
          end else begin
            credit_d = CREDIT_W'(credit_ext - price_ext);
            dec_en   = 1'b1;
            out_d    = 1'b1;
            item_d   = sel;
            state_d  = ST_DISPENSE;
          end
        end else if (restock) begin
          coin_reject_d = coin_present;
          reload_en     = sel_ok;
          state_d       = (credit_q != '0) ? ST_CREDIT : ST_IDLE;
        end else if (coin_present) begin
          if (sum_ext <= SUM_W'(MAX_CREDIT)) begin
            credit_d = CREDIT_W'(sum_ext);
            state_d  = ST_CREDIT;
          end else begin
            coin_reject_d = 1'b1;
            state_d       = (credit_q != '0) ? ST_CREDIT : ST_IDLE;
          end
        end
      end
      ST_DISPENSE: begin
        coin_reject_d = coin_present;
        state_d       = (credit_q != '0) ? ST_CHANGE : ST_IDLE;
      end
      default: begin
        coin_reject_d = coin_present;
        if (credit_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          change_d = gc;
          credit_d = credit_q - CREDIT_W'(coin_value(gc));
        end
      end
    endcase

    busy_d = (state_d == ST_DISPENSE) || (state_d == ST_CHANGE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      credit_q      <= '0;
      out_q         <= 1'b0;
      item_q        <= '0;
      change_q      <= COIN_NONE;
      coin_reject_q <= 1'b0;
      vend_fail_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      credit_q      <= credit_d;
      out_q         <= out_d;
      item_q        <= item_d;
      change_q      <= change_d;
      coin_reject_q <= coin_reject_d;
      vend_fail_q   <= vend_fail_d;
      busy_q        <= busy_d;
    end
  end

  assign out         = out_q;
  assign item        = item_q;
  assign change      = change_q;
  assign coin_reject = coin_reject_q;
  assign vend_fail   = vend_fail_q;
  assign busy        = busy_q;
  assign credit      = credit_q;
  assign c_state     = state_q;

endmodule

// File: tb/tb_vending_machine_multi.sv
module tb_vending_machine_multi;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] in;
  logic [1:0] sel;
  logic       vend_req, cancel, restock;
  logic       out;
  logic [1:0] item;
  logic [1:0] change;
  logic       coin_reject, vend_fail, busy;
  logic [3:0] sold_out;
  logic [5:0] credit;
  logic [1:0] c_state;

  int total = 0;
  int bad   = 0;

  vending_machine_multi dut (
    .clk        (clk),
    .rst        (rst),
    .in         (in),
    .sel        (sel),
    .vend_req   (vend_req),
    .cancel     (cancel),
    .restock    (restock),
    .out        (out),
    .item       (item),
    .change     (change),
    .coin_reject(coin_reject),
    .vend_fail  (vend_fail),
    .busy       (busy),
    .sold_out   (sold_out),
    .credit     (credit),
    .c_state    (c_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive one edge's worth of inputs, then clear them 1 time unit after the edge.
  task automatic cyc(input logic [1:0] c, input logic v, input logic [1:0] s,
                     input logic ca, input logic r);
    in = c; vend_req = v; sel = s; cancel = ca; restock = r;
    @(posedge clk);
    #1;
    in = 2'b00; vend_req = 1'b0; sel = 2'd0; cancel = 1'b0; restock = 1'b0;
  endtask

  // Buy item 0 (price 3) from an empty credit: 10 rs + 5 rs, vend, back to IDLE.
  task automatic buy0(input int k, input logic exp_sold);
    cyc(2'b10, 0, 0, 0, 0);
    cyc(2'b01, 0, 0, 0, 0);
    chk("buy0_credit", credit, 3);
    cyc(2'b00, 1, 0, 0, 0);
    chk("buy0_out", out, 1);
    chk("buy0_credit_after", credit, 0);
    chk("buy0_sold", sold_out[0], exp_sold);
    cyc(2'b00, 0, 0, 0, 0);
    chk("buy0_idle", c_state, 0);
  endtask

  initial begin
    rst = 1'b1; in = 2'b00; sel = 2'd0; vend_req = 0; cancel = 0; restock = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_credit", credit, 0);
    chk("rst_state", c_state, 0);
    chk("rst_out", out, 0);
    chk("rst_change", change, 0);
    chk("rst_sold", sold_out, 0);
    rst = 1'b0;

    // Two 10 rs coins, buy item 0, one 5 rs coin of change.
    cyc(2'b10, 0, 0, 0, 0);
    chk("t1_credit2", credit, 2);
    chk("t1_state_credit", c_state, 1);
    cyc(2'b10, 0, 0, 0, 0);
    chk("t1_credit4", credit, 4);
    cyc(2'b00, 1, 0, 0, 0);
    chk("t1_out", out, 1);
    chk("t1_item", item, 0);
    chk("t1_credit1", credit, 1);
    chk("t1_state_disp", c_state, 2);
    cyc(2'b00, 0, 0, 0, 0);
    chk("t1_state_change", c_state, 3);
    chk("t1_out_low", out, 0);
    chk("t1_change_none", change, 0);
    cyc(2'b00, 0, 0, 0, 0);
    chk("t1_change_5", change, 1);
    chk("t1_credit0", credit, 0);
    cyc(2'b00, 0, 0, 0, 0);
    chk("t1_change_end", change, 0);
    chk("t1_state_idle", c_state, 0);

    // 20+20+10 -> 10 units, buy item 3 (price 8), 10 rs change, busy 3 cycles.
    cyc(2'b11, 0, 0, 0, 0);
    cyc(2'b11, 0, 0, 0, 0);
    cyc(2'b10, 0, 0, 0, 0);
    chk("t2_credit10", credit, 10);
    chk("t2_busy_idle", busy, 0);
    cyc(2'b00, 1, 3, 0, 0);
    chk("t2_out", out, 1);
    chk("t2_item", item, 3);
    chk("t2_credit2", credit, 2);
    chk("t2_busy1", busy, 1);
    cyc(2'b00, 0, 0, 0, 0);
    chk("t2_busy2", busy, 1);
    cyc(2'b00, 0, 0, 0, 0);
    chk("t2_busy3", busy, 1);
    chk("t2_change_10", change, 2);
    cyc(2'b00, 0, 0, 0, 0);
    chk("t2_busy_done", busy, 0);
    chk("t2_change_end", change, 0);
    chk("t2_state_idle", c_state, 0);

    // Fill to the 40-unit ceiling, reject overflow, cancel for ten 20 rs coins.
    for (int k = 0; k < 9; k++) cyc(2'b11, 0, 0, 0, 0);
    cyc(2'b10, 0, 0, 0, 0);
    chk("t3_credit38", credit, 38);
    cyc(2'b10, 0, 0, 0, 0);
    chk("t3_credit40", credit, 40);
    chk("t3_no_reject", coin_reject, 0);
    cyc(2'b01, 0, 0, 0, 0);
    chk("t3_reject", coin_reject, 1);
    chk("t3_credit_kept", credit, 40);
    cyc(2'b00, 0, 0, 1, 0);
    chk("t3_reject_pulse", coin_reject, 0);
    chk("t3_state_change", c_state, 3);
    for (int k = 1; k <= 10; k++) begin
      cyc(2'b00, 0, 0, 0, 0);
      chk("t3_change_20", change, 3);
      chk("t3_credit_dec", credit, 40 - 4 * k);
    end
    cyc(2'b00, 0, 0, 0, 0);
    chk("t3_change_end", change, 0);
    chk("t3_state_idle", c_state, 0);

    // Insufficient credit with a coin on the same edge.
    cyc(2'b10, 0, 0, 0, 0);
    cyc(2'b01, 1, 1, 0, 0);
    chk("t4_vend_fail", vend_fail, 1);
    chk("t4_coin_reject", coin_reject, 1);
    chk("t4_credit_kept", credit, 2);
    chk("t4_state_credit", c_state, 1);
    chk("t4_no_out", out, 0);
    cyc(2'b00, 0, 0, 0, 0);
    chk("t4_fail_pulse", vend_fail, 0);
    cyc(2'b00, 0, 0, 1, 0);
    cyc(2'b00, 0, 0, 0, 0);
    chk("t4_refund_10", change, 2);
    cyc(2'b00, 0, 0, 0, 0);
    chk("t4_state_idle", c_state, 0);

    // Item 0 has 4 left; restock, sell all five, sixth fails, restock again.
    cyc(2'b00, 0, 0, 0, 1);
    for (int k = 0; k < 5; k++) buy0(k, (k == 4));
    chk("t5_sold_out", sold_out, 4'b0001);
    cyc(2'b10, 0, 0, 0, 0);
    cyc(2'b01, 0, 0, 0, 0);
    cyc(2'b00, 1, 0, 0, 0);
    chk("t5_vend_fail", vend_fail, 1);
    chk("t5_no_out", out, 0);
    chk("t5_credit_kept", credit, 3);
    cyc(2'b00, 0, 0, 0, 1);
    chk("t5_restocked", sold_out, 4'b0000);
    chk("t5_state_credit", c_state, 1);

    // Reset in the middle of a refund.
    cyc(2'b10, 0, 0, 0, 0);
    cyc(2'b01, 0, 0, 0, 0);
    chk("t6_credit6", credit, 6);
    cyc(2'b00, 0, 0, 1, 0);
    chk("t6_state_change", c_state, 3);
    cyc(2'b00, 0, 0, 0, 0);
    chk("t6_change_20", change, 3);
    chk("t6_credit2", credit, 2);
    cyc(2'b00, 1, 0, 0, 0);           // ignored while busy
    chk("t6_busy_no_fail", vend_fail, 0);
    rst = 1'b1;
    #1;
    chk("t6_rst_credit", credit, 0);
    chk("t6_rst_change", change, 0);
    chk("t6_rst_state", c_state, 0);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("t6_after_rst_state", c_state, 0);
    for (int k = 0; k < 5; k++) buy0(k, (k == 4));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
